// File: rtl/lsu_mem_access_if.sv
// Data bus interface for the memory-access stage.
// Request side:  req, we, addr (word aligned), be (byte enables), wdata.
// Response side: gnt (request accepted), rvalid (load data / store ack),
//                rdata (load data), err (response error, qualified by rvalid).
// master: the LSU drives the request and observes the response.
// slave:  the memory or bus fabric.
interface lsu_mem_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/lsu_mem_access.sv
// Memory-access stage, the consumer side of the EX/MEM register.
// Runs load/store uops on the data bus (req/gnt/rvalid), aligns and extends load data,
// flags misalignment and bus errors in exception_o, and stalls the pipeline via
// stall_req_o until the access completes. Non-memory uops pass straight through.
// Ports: clk_i / n_rst_i (sync, active-high); flush_i from ctrl; GPR, uop, memory, CSR,
// exception, pc and instruction bundles in from EX/MEM and out to MEM/WB;
// dbus (master modport) to the data bus; stall_req_o to ctrl.
module lsu_mem_access #(
  parameter int unsigned LD_MISALIGN_BIT = 4,
  parameter int unsigned LD_FAULT_BIT    = 5,
  parameter int unsigned ST_MISALIGN_BIT = 6,
  parameter int unsigned ST_FAULT_BIT    = 7
) (
  input  logic                 clk_i,
  input  logic                 n_rst_i,
  input  logic                 flush_i,
  input  logic                 rd_we_i,
  input  logic [4:0]           rd_wa_i,
  input  logic [31:0]          rd_wd_i,
  input  logic [7:0]           uop_i,
  input  logic [31:0]          mem_a_i,
  input  logic [31:0]          mem_wd_i,
  input  logic                 csr_we_i,
  input  logic [31:0]          csr_waddr_i,
  input  logic [31:0]          csr_wdata_i,
  input  logic [31:0]          exception_i,
  input  logic [31:0]          pc_i,
  input  logic [31:0]          ins_i,
  lsu_mem_access_if.master     dbus,
  output logic                 stall_req_o,
  output logic                 rd_we_o,
  output logic [4:0]           rd_wa_o,
  output logic [31:0]          rd_wd_o,
  output logic                 csr_we_o,
  output logic [31:0]          csr_waddr_o,
  output logic [31:0]          csr_wdata_o,
  output logic [31:0]          exception_o,
  output logic [31:0]          pc_o,
  output logic [31:0]          ins_o
);

  localparam logic [7:0] UOP_CODE_LB  = 8'h20;
  localparam logic [7:0] UOP_CODE_LH  = 8'h21;
  localparam logic [7:0] UOP_CODE_LW  = 8'h22;
  localparam logic [7:0] UOP_CODE_LBU = 8'h23;
  localparam logic [7:0] UOP_CODE_LHU = 8'h24;
  localparam logic [7:0] UOP_CODE_SB  = 8'h25;
  localparam logic [7:0] UOP_CODE_SH  = 8'h26;
  localparam logic [7:0] UOP_CODE_SW  = 8'h27;

  typedef enum logic [1:0] {StIdle, StReq, StResp, StAbort} state_e;

  state_e      state_q, state_d;
  logic        granted_q, granted_d;  // ABORT only: the abandoned request was already granted
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [7:0]  uop_q;
  logic [1:0]  a_lo_q;

  logic        is_load, is_store, is_mem, is_byte, is_half, is_word, misaligned;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, mis_mask, fault_mask, lane, load_data;
  logic        latch, stall, req_c;

  // Uop decode and request formation for the incoming op
  always_comb begin
    is_load = 1'b0;
    is_store = 1'b0;
    is_byte = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    case (uop_i)
      UOP_CODE_LB, UOP_CODE_LBU: begin is_load = 1'b1; is_byte = 1'b1; end
      UOP_CODE_LH, UOP_CODE_LHU: begin is_load = 1'b1; is_half = 1'b1; end
      UOP_CODE_LW:               begin is_load = 1'b1; is_word = 1'b1; end
      UOP_CODE_SB:               begin is_store = 1'b1; is_byte = 1'b1; end
      UOP_CODE_SH:               begin is_store = 1'b1; is_half = 1'b1; end
      UOP_CODE_SW:               begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
    is_mem     = is_load | is_store;
    misaligned = (is_half & mem_a_i[0]) | (is_word & (mem_a_i[1:0] != 2'b00));
    mis_mask   = misaligned ? (32'd1 << (is_load ? LD_MISALIGN_BIT : ST_MISALIGN_BIT)) : 32'd0;
    if (is_byte) begin
      be_new    = 4'b0001 << mem_a_i[1:0];
      wdata_new = {4{mem_wd_i[7:0]}};
    end else if (is_half) begin
      be_new    = 4'b0011 << mem_a_i[1:0];
      wdata_new = {2{mem_wd_i[15:0]}};
    end else begin
      be_new    = 4'b1111;
      wdata_new = mem_wd_i;
    end
  end

  // Load lane select and extension, from the latched uop and offset
  always_comb begin
    lane       = dbus.rdata >> {a_lo_q, 3'b000};
    fault_mask = 32'd1 << (we_q ? ST_FAULT_BIT : LD_FAULT_BIT);
    case (uop_q)
      UOP_CODE_LB:  load_data = {{24{lane[7]}}, lane[7:0]};
      UOP_CODE_LBU: load_data = {24'd0, lane[7:0]};
      UOP_CODE_LH:  load_data = {{16{lane[15]}}, lane[15:0]};
      UOP_CODE_LHU: load_data = {16'd0, lane[15:0]};
      default:      load_data = dbus.rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    granted_d   = granted_q;
    latch       = 1'b0;
    stall       = 1'b0;
    req_c       = 1'b0;
    rd_we_o     = rd_we_i;
    rd_wa_o     = rd_wa_i;
    rd_wd_o     = rd_wd_i;
    csr_we_o    = csr_we_i;
    csr_waddr_o = csr_waddr_i;
    csr_wdata_o = csr_wdata_i;
    exception_o = exception_i;
    pc_o        = pc_i;
    ins_o       = ins_i;
    unique case (state_q)
      StIdle, StAbort: begin
        if (state_q == StAbort) begin
          // A request, once raised, stays up until granted; its response is dropped
          req_c = ~granted_q;
          if (!granted_q && dbus.gnt) granted_d = 1'b1;
          if (granted_q && dbus.rvalid) begin
            state_d   = StIdle;
            granted_d = 1'b0;
          end
        end
        if (is_mem) begin
          rd_we_o  = 1'b0;
          csr_we_o = 1'b0;
          if (misaligned || (exception_i != 32'd0)) begin
            exception_o = exception_i | mis_mask;
          end else if (!flush_i) begin
            stall = 1'b1;
            if (state_q == StIdle) begin
              state_d = StReq;
              latch   = 1'b1;
            end
          end
        end
      end
      StReq: begin
        req_c    = 1'b1;
        rd_we_o  = 1'b0;
        csr_we_o = 1'b0;
        if (flush_i) begin
          state_d   = StAbort;
          granted_d = dbus.gnt;
        end else begin
          stall = 1'b1;
          if (dbus.gnt) state_d = StResp;
        end
      end
      StResp: begin
        rd_we_o  = 1'b0;
        csr_we_o = 1'b0;
        if (dbus.rvalid) begin
          state_d = StIdle;
          if (!flush_i) begin
            if (dbus.err) begin
              exception_o = exception_i | fault_mask;
            end else begin
              csr_we_o = csr_we_i;
              if (!we_q) begin
                rd_we_o = rd_we_i;
                rd_wd_o = load_data;
              end
            end
          end
        end else if (flush_i) begin
          state_d   = StAbort;
          granted_d = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Reset takes effect on the outputs in the same cycle it is asserted
    if (n_rst_i) begin
      rd_we_o  = 1'b0;
      csr_we_o = 1'b0;
    end
  end

  assign stall_req_o = stall & ~n_rst_i;
  assign dbus.req    = req_c & ~n_rst_i;
  assign dbus.we     = we_q;
  assign dbus.addr   = addr_q;
  assign dbus.be     = be_q;
  assign dbus.wdata  = wdata_q;

  always_ff @(posedge clk_i) begin
    if (n_rst_i) begin
      state_q   <= StIdle;
      granted_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      uop_q     <= 8'd0;
      a_lo_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      granted_q <= granted_d;
      if (latch) begin
        we_q    <= is_store;
        addr_q  <= {mem_a_i[31:2], 2'b00};
        be_q    <= be_new;
        wdata_q <= wdata_new;
        uop_q   <= uop_i;
        a_lo_q  <= mem_a_i[1:0];
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access: loads, stores, alignment faults, bus errors,
// flush/abort and reset in mid-transaction, with hand-computed expected values.
module tb_lsu_mem_access;
  localparam logic [7:0] NOP = 8'h01;
  localparam logic [7:0] LB  = 8'h20;
  localparam logic [7:0] LH  = 8'h21;
  localparam logic [7:0] LW  = 8'h22;
  localparam logic [7:0] LBU = 8'h23;
  localparam logic [7:0] LHU = 8'h24;
  localparam logic [7:0] SB  = 8'h25;
  localparam logic [7:0] SH  = 8'h26;
  localparam logic [7:0] SW  = 8'h27;

  logic        clk_i = 1'b0;
  logic        n_rst_i, flush_i, rd_we_i, csr_we_i;
  logic [4:0]  rd_wa_i;
  logic [31:0] rd_wd_i, mem_a_i, mem_wd_i, csr_waddr_i, csr_wdata_i, exception_i, pc_i, ins_i;
  logic [7:0]  uop_i;
  logic        stall_req_o, rd_we_o, csr_we_o;
  logic [4:0]  rd_wa_o;
  logic [31:0] rd_wd_o, csr_waddr_o, csr_wdata_o, exception_o, pc_o, ins_o;

  int n_vec = 0;
  int n_miss = 0;

  lsu_mem_access_if dbus ();

  lsu_mem_access dut (
    .clk_i       (clk_i),
    .n_rst_i     (n_rst_i),
    .flush_i     (flush_i),
    .rd_we_i     (rd_we_i),
    .rd_wa_i     (rd_wa_i),
    .rd_wd_i     (rd_wd_i),
    .uop_i       (uop_i),
    .mem_a_i     (mem_a_i),
    .mem_wd_i    (mem_wd_i),
    .csr_we_i    (csr_we_i),
    .csr_waddr_i (csr_waddr_i),
    .csr_wdata_i (csr_wdata_i),
    .exception_i (exception_i),
    .pc_i        (pc_i),
    .ins_i       (ins_i),
    .dbus        (dbus),
    .stall_req_o (stall_req_o),
    .rd_we_o     (rd_we_o),
    .rd_wa_o     (rd_wa_o),
    .rd_wd_o     (rd_wd_o),
    .csr_we_o    (csr_we_o),
    .csr_waddr_o (csr_waddr_o),
    .csr_wdata_o (csr_wdata_o),
    .exception_o (exception_o),
    .pc_o        (pc_o),
    .ins_o       (ins_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    uop_i = NOP; rd_we_i = 1'b0; rd_wd_i = 32'd0; mem_a_i = 32'd0; mem_wd_i = 32'd0;
    flush_i = 1'b0; exception_i = 32'd0;
    dbus.gnt = 1'b0; dbus.rvalid = 1'b0; dbus.err = 1'b0; dbus.rdata = 32'd0;
  endtask

  // One access: op at cycle N, gnt after gnt_wait extra REQ cycles, rvalid the cycle after.
  task automatic run_access(input string tag, input logic [7:0] uop, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rdata, input logic err,
                            input int gnt_wait, input logic [31:0] exp_addr,
                            input logic [31:0] exp_rd_wd, input logic exp_rd_we,
                            input logic [31:0] exp_exc, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
    logic st;
    st = (uop == SB) || (uop == SH) || (uop == SW);
    uop_i = uop; mem_a_i = a; mem_wd_i = wd; rd_we_i = 1'b1; rd_wd_i = 32'd0;
    #1;
    check_eq({tag, "_stall_n"}, {31'd0, stall_req_o}, 32'd1);
    check_eq({tag, "_req_n"}, {31'd0, dbus.req}, 32'd0);
    for (int k = 0; k <= gnt_wait; k++) begin
      next_cycle();
      dbus.gnt = (k == gnt_wait);
      #1;
      check_eq({tag, "_req"}, {31'd0, dbus.req}, 32'd1);
      check_eq({tag, "_addr"}, dbus.addr, exp_addr);
      check_eq({tag, "_we"}, {31'd0, dbus.we}, {31'd0, st});
      check_eq({tag, "_stall_req"}, {31'd0, stall_req_o}, 32'd1);
      check_eq({tag, "_rdwe_req"}, {31'd0, rd_we_o}, 32'd0);
      if (st) begin
        check_eq({tag, "_be"}, {28'd0, dbus.be}, {28'd0, exp_be});
        check_eq({tag, "_wdata"}, dbus.wdata, exp_wdata);
      end
    end
    next_cycle();
    dbus.gnt = 1'b0; dbus.rvalid = 1'b1; dbus.rdata = rdata; dbus.err = err;
    #1;
    check_eq({tag, "_stall_done"}, {31'd0, stall_req_o}, 32'd0);
    check_eq({tag, "_rd_we"}, {31'd0, rd_we_o}, {31'd0, exp_rd_we});
    check_eq({tag, "_rd_wd"}, rd_wd_o, exp_rd_wd);
    check_eq({tag, "_exc"}, exception_o, exp_exc);
    check_eq({tag, "_req_done"}, {31'd0, dbus.req}, 32'd0);
    next_cycle();
    idle_inputs();
    #1;
    check_eq({tag, "_stall_after"}, {31'd0, stall_req_o}, 32'd0);
  endtask

  // Misaligned or pre-faulted op: no request, flagged exception, no stall.
  task automatic run_reject(input string tag, input logic [7:0] uop, input logic [31:0] a,
                            input logic [31:0] exc_in, input logic [31:0] exp_exc);
    uop_i = uop; mem_a_i = a; rd_we_i = 1'b1; exception_i = exc_in;
    #1;
    check_eq({tag, "_req"}, {31'd0, dbus.req}, 32'd0);
    check_eq({tag, "_stall"}, {31'd0, stall_req_o}, 32'd0);
    check_eq({tag, "_exc"}, exception_o, exp_exc);
    check_eq({tag, "_rd_we"}, {31'd0, rd_we_o}, 32'd0);
    next_cycle();
    idle_inputs();
    #1;
    check_eq({tag, "_req_next"}, {31'd0, dbus.req}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    n_rst_i = 1'b1; rd_wa_i = 5'd7; csr_we_i = 1'b0; csr_waddr_i = 32'h0000_0300;
    csr_wdata_i = 32'd0; pc_i = 32'h0000_0100; ins_i = 32'h0000_0013;
    rd_we_i = 1'b1;
    next_cycle();
    next_cycle();
    check_eq("rst_req", {31'd0, dbus.req}, 32'd0);
    check_eq("rst_we", {31'd0, dbus.we}, 32'd0);
    check_eq("rst_be", {28'd0, dbus.be}, 32'd0);
    check_eq("rst_addr", dbus.addr, 32'd0);
    check_eq("rst_wdata", dbus.wdata, 32'd0);
    check_eq("rst_stall", {31'd0, stall_req_o}, 32'd0);
    check_eq("rst_rd_we", {31'd0, rd_we_o}, 32'd0);
    n_rst_i = 1'b0;
    next_cycle();

    // Pass-through of a non-memory uop
    uop_i = NOP; rd_we_i = 1'b1; rd_wd_i = 32'h0000_55AA; csr_we_i = 1'b1;
    csr_wdata_i = 32'hC0DE_0001; exception_i = 32'h0000_0002;
    #1;
    check_eq("pt_rd_we", {31'd0, rd_we_o}, 32'd1);
    check_eq("pt_rd_wd", rd_wd_o, 32'h0000_55AA);
    check_eq("pt_csr_we", {31'd0, csr_we_o}, 32'd1);
    check_eq("pt_csr_wdata", csr_wdata_o, 32'hC0DE_0001);
    check_eq("pt_exc", exception_o, 32'h0000_0002);
    check_eq("pt_stall", {31'd0, stall_req_o}, 32'd0);
    check_eq("pt_req", {31'd0, dbus.req}, 32'd0);
    next_cycle();
    idle_inputs();
    csr_we_i = 1'b0;

    run_access("lw",  LW,  32'h1000, 32'd0, 32'hDEAD_BEEF, 1'b0, 0, 32'h1000,
               32'hDEAD_BEEF, 1'b1, 32'd0, 4'b0000, 32'd0);
    run_access("lb",  LB,  32'h1003, 32'd0, 32'h80FF_FFFF, 1'b0, 0, 32'h1000,
               32'hFFFF_FF80, 1'b1, 32'd0, 4'b0000, 32'd0);
    run_access("lbu", LBU, 32'h1003, 32'd0, 32'h80FF_FFFF, 1'b0, 0, 32'h1000,
               32'h0000_0080, 1'b1, 32'd0, 4'b0000, 32'd0);
    run_access("lhu", LHU, 32'h1002, 32'd0, 32'h80FF_FFFF, 1'b0, 0, 32'h1000,
               32'h0000_80FF, 1'b1, 32'd0, 4'b0000, 32'd0);
    run_access("lh",  LH,  32'h1002, 32'd0, 32'h80FF_1234, 1'b0, 1, 32'h1000,
               32'hFFFF_80FF, 1'b1, 32'd0, 4'b0000, 32'd0);
    run_access("sh",  SH,  32'h2002, 32'h1234_ABCD, 32'd0, 1'b0, 3, 32'h2000,
               32'd0, 1'b0, 32'd0, 4'b1100, 32'hABCD_ABCD);
    run_access("sw",  SW,  32'h2004, 32'hCAFE_F00D, 32'd0, 1'b0, 0, 32'h2004,
               32'd0, 1'b0, 32'd0, 4'b1111, 32'hCAFE_F00D);
    run_access("lw_err", LW, 32'h1000, 32'd0, 32'h1234_5678, 1'b1, 0, 32'h1000,
               32'd0, 1'b0, 32'h0000_0020, 4'b0000, 32'd0);
    run_access("sb_err", SB, 32'h2001, 32'h0000_00A5, 32'd0, 1'b1, 0, 32'h2000,
               32'd0, 1'b0, 32'h0000_0080, 4'b0010, 32'hA5A5_A5A5);

    run_reject("lw_mis", LW, 32'h1001, 32'd0, 32'h0000_0010);
    run_reject("sw_mis", SW, 32'h1002, 32'd0, 32'h0000_0040);
    run_reject("lw_exc", LW, 32'h1000, 32'h0000_0002, 32'h0000_0002);

    // Flush in REQ before gnt: request held to gnt, response dropped, next op waits for IDLE
    uop_i = LW; mem_a_i = 32'h3000; rd_we_i = 1'b1;
    #1;
    check_eq("fl_stall_n", {31'd0, stall_req_o}, 32'd1);
    next_cycle();
    flush_i = 1'b1;
    #1;
    check_eq("fl_req_flush", {31'd0, dbus.req}, 32'd1);
    check_eq("fl_stall_flush", {31'd0, stall_req_o}, 32'd0);
    next_cycle();
    flush_i = 1'b0; mem_a_i = 32'h1000; dbus.gnt = 1'b1;
    #1;
    check_eq("fl_req_held", {31'd0, dbus.req}, 32'd1);
    check_eq("fl_addr_held", dbus.addr, 32'h3000);
    check_eq("fl_stall_abort", {31'd0, stall_req_o}, 32'd1);
    check_eq("fl_rdwe_abort", {31'd0, rd_we_o}, 32'd0);
    next_cycle();
    dbus.gnt = 1'b0; dbus.rvalid = 1'b1; dbus.rdata = 32'h1111_1111;
    #1;
    check_eq("fl_req_drop", {31'd0, dbus.req}, 32'd0);
    check_eq("fl_rdwe_discard", {31'd0, rd_we_o}, 32'd0);
    check_eq("fl_stall_discard", {31'd0, stall_req_o}, 32'd1);
    next_cycle();
    dbus.rvalid = 1'b0;
    #1;
    check_eq("fl_idle_req", {31'd0, dbus.req}, 32'd0);
    check_eq("fl_idle_stall", {31'd0, stall_req_o}, 32'd1);
    next_cycle();
    dbus.gnt = 1'b1;
    #1;
    check_eq("fl_reissue_req", {31'd0, dbus.req}, 32'd1);
    check_eq("fl_reissue_addr", dbus.addr, 32'h1000);
    next_cycle();
    dbus.gnt = 1'b0; dbus.rvalid = 1'b1; dbus.rdata = 32'h2222_2222;
    #1;
    check_eq("fl_reissue_wd", rd_wd_o, 32'h2222_2222);
    check_eq("fl_reissue_we", {31'd0, rd_we_o}, 32'd1);
    next_cycle();
    idle_inputs();

    // Reset while waiting in RESP
    uop_i = LW; mem_a_i = 32'h4000; rd_we_i = 1'b1;
    next_cycle();
    dbus.gnt = 1'b1;
    next_cycle();
    dbus.gnt = 1'b0;
    #1;
    check_eq("rr_stall_resp", {31'd0, stall_req_o}, 32'd1);
    n_rst_i = 1'b1;
    next_cycle();
    n_rst_i = 1'b0;
    idle_inputs();
    #1;
    check_eq("rr_req", {31'd0, dbus.req}, 32'd0);
    check_eq("rr_stall", {31'd0, stall_req_o}, 32'd0);
    next_cycle();

    run_access("lw_post", LW, 32'h5008, 32'd0, 32'h0BAD_F00D, 1'b0, 0, 32'h5008,
               32'h0BAD_F00D, 1'b1, 32'd0, 4'b0000, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
